// File: rtl/seq_divider_pkg.sv
// Shared definitions for the sequential restoring divider: state codes and width helpers.
package seq_divider_pkg;

    localparam int unsigned DefaultN = 4;

    typedef logic [1:0] state_t;

    localparam state_t StIdle = 2'd0;
    localparam state_t StBusy = 2'd1;
    localparam state_t StDone = 2'd2;

    // Step counter must hold 2N-1, one count per quotient bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return $clog2(2 * n);
    endfunction

    localparam int unsigned DefaultCntW = cnt_width(DefaultN);

endpackage

// File: rtl/seq_divider_if.sv
// Request/response handshake bundle for seq_divider.
interface seq_divider_if #(
    parameter int unsigned N = seq_divider_pkg::DefaultN
);

    logic             in_valid;
    logic             in_ready;
    logic [2*N-1:0]   dividend;
    logic [N-1:0]     divisor;
    logic             out_valid;
    logic             out_ready;
    logic [2*N-1:0]   quotient;
    logic [N-1:0]     remainder;
    logic             div_by_zero;

    modport master (
        output in_valid, dividend, divisor, out_ready,
        input  in_ready, out_valid, quotient, remainder, div_by_zero
    );

    modport slave (
        input  in_valid, dividend, divisor, out_ready,
        output in_ready, out_valid, quotient, remainder, div_by_zero
    );

endinterface

// File: rtl/seq_divider_div_step.sv
// One combinational restoring-division step: shift in the next dividend bit, trial-subtract.
module div_step
    import seq_divider_pkg::*;
#(
    parameter int unsigned N = DefaultN
) (
    input  logic [N-1:0]   r,
    input  logic [2*N-1:0] q,
    input  logic [N-1:0]   divisor,
    output logic [N-1:0]   r_next,
    output logic [2*N-1:0] q_next
);

    logic [N:0]   r_sh;
    logic [N-1:0] r_sub;
    logic         ge;

    // The stored remainder is always below the divisor, so the N+1-bit partial
    // remainder only needs its low N bits carried between steps.
    assign r_sh   = {r, q[2*N-1]};
    assign ge     = r_sh >= {1'b0, divisor};
    assign r_sub  = r_sh[N-1:0] - divisor;
    assign r_next = ge ? r_sub : r_sh[N-1:0];
    assign q_next = {q[2*N-2:0], ge};

endmodule

// File: rtl/seq_divider.sv
// Iterative restoring divider: 2N-bit dividend / N-bit divisor, one quotient bit per clock.
module seq_divider
    import seq_divider_pkg::*;
#(
    parameter int unsigned N = DefaultN
) (
    input  logic          clk,
    input  logic          reset,
    seq_divider_if.slave  bus
);

    localparam int unsigned CntW = cnt_width(N);

    state_t           state_q, state_d;
    logic [2*N-1:0]   quot_q, quot_d;
    logic [N-1:0]     rem_q, rem_d;
    logic [N-1:0]     dvsr_q, dvsr_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic             dbz_q, dbz_d;
    logic [N-1:0]     step_r;
    logic [2*N-1:0]   step_q;

    div_step #(
        .N(N)
    ) u_step (
        .r       (rem_q),
        .q       (quot_q),
        .divisor (dvsr_q),
        .r_next  (step_r),
        .q_next  (step_q)
    );

    always_comb begin
        state_d = state_q;
        quot_d  = quot_q;
        rem_d   = rem_q;
        dvsr_d  = dvsr_q;
        cnt_d   = cnt_q;
        dbz_d   = dbz_q;
        unique case (state_q)
            StIdle: begin
                if (bus.in_valid) begin
                    dvsr_d = bus.divisor;
                    rem_d  = '0;
                    cnt_d  = CntW'(2 * N - 1);
                    if (bus.divisor == '0) begin
                        quot_d  = '1;
                        dbz_d   = 1'b1;
                        state_d = StDone;
                    end else begin
                        quot_d  = bus.dividend;
                        dbz_d   = 1'b0;
                        state_d = StBusy;
                    end
                end
            end
            StBusy: begin
                quot_d = step_q;
                rem_d  = step_r;
                cnt_d  = cnt_q - CntW'(1);
                if (cnt_q == '0) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                if (bus.out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            quot_q  <= '0;
            rem_q   <= '0;
            dvsr_q  <= '0;
            cnt_q   <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            dvsr_q  <= dvsr_d;
            cnt_q   <= cnt_d;
            dbz_q   <= dbz_d;
        end
    end

    assign bus.in_ready    = (state_q == StIdle);
    assign bus.out_valid   = (state_q == StDone);
    assign bus.quotient    = quot_q;
    assign bus.remainder   = rem_q;
    assign bus.div_by_zero = dbz_q;

endmodule

// File: doc/seq_divider.md
# seq_divider

Iterative restoring divider, the inverse of the 4x4 fast multiplier: it takes a 2N-bit dividend (a multiplier product) and an N-bit divisor, and returns quotient and remainder after a fixed number of cycles. It sits behind a valid/ready request port and a valid/ready response port, so it can be placed after the multiplier for round-trip checks or used standalone in datapath examples. It resolves one quotient bit per clock.

## Interface

- N, default 4: divisor and remainder width; dividend and quotient are 2N bits.
- clk  input  1  single clock, all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  request present.
- in_ready  output  1  divider can accept a request.
- dividend  input  2N  numerator, sampled on the accept edge.
- divisor  input  N  denominator, sampled on the accept edge.
- out_valid  output  1  result present.
- out_ready  input  1  consumer takes the result.
- quotient  output  2N  dividend / divisor, unsigned.
- remainder  output  N  dividend mod divisor, unsigned.
- div_by_zero  output  1  result came from a request with divisor == 0.

## Operation

- The FSM has three states:
  - IDLE: in_ready = 1, out_valid = 0.
  - BUSY: both 0.
  - DONE: in_ready = 0, out_valid = 1.
- Accept happens when in_valid && in_ready at a rising edge.
- On accept:
  - Latch dividend into the quotient shift register and divisor into the divisor register.
  - Clear the partial remainder (N+1 bits).
  - Set step counter = 2N-1.
  - If divisor != 0, go to BUSY. If divisor == 0, go directly to DONE with quotient = all ones (2^(2N)-1), remainder = 0, div_by_zero = 1.
- Each BUSY edge performs one restoring step:
  - r' = {r[N-1:0], q[2N-1]}.
  - q shifts left by one.
  - If r' >= divisor: r = r' - divisor and q[0] = 1. Otherwise r = r' and q[0] = 0.
  - Counter decrements. The edge that processes counter == 0 moves to DONE.
- Width rules:
  - Partial remainder is N+1 bits internally; the remainder output is its low N bits.
  - The high bit is always 0 after a step.
  - No overflow is possible because the quotient is 2N bits.
- DONE:
  - quotient, remainder and div_by_zero are held stable until out_valid && out_ready at an edge, then the FSM returns to IDLE.
  - There is no bypass: a new request cannot be accepted in the same edge as result retirement.
- in_valid, dividend and divisor are ignored outside IDLE.
- Reset at any time, including mid-BUSY or in DONE, forces IDLE next edge and aborts the operation with no result. After reset:
  - in_ready = 1, out_valid = 0.
  - quotient = 0, remainder = 0, div_by_zero = 0.
- Unsigned only.

## Timing

- Accept at edge E0 with divisor != 0: out_valid is high from edge E0+2N (N=4: 8 edges later), giving 2N BUSY cycles.
- Divide by zero: out_valid is high from edge E0+1.
- With out_ready held high: in_ready rises at edge E0+2N+1.
  - Back-to-back throughput is one result per 2N+2 cycles.
- in_ready and out_valid are registered-state decodes. Neither depends combinationally on in_valid or out_ready.
- Result outputs change only at accept, during BUSY, or on reset. They are constant throughout DONE.

## Structure

- Shared package seq_divider_pkg holds:
  - the state enum (IDLE, BUSY, DONE);
  - the default width constant N = 4;
  - the step counter width $clog2(2N).
- One sub-module, div_step: combinational single restoring step.
  - Inputs: r, q, divisor.
  - Outputs: next r, next q.
  - It is instantiated once by the FSM module, which owns the registers, counter and handshake.

## Test plan

- Round trip with the multiplier (N=4): dividend = 6, divisor = 3 -> quotient = 2, remainder = 0, div_by_zero = 0. out_valid rises exactly 8 edges after accept.
- Non-exact division: 200 / 7 -> quotient = 28, remainder = 4. Also 255 / 1 -> quotient = 255, remainder = 0.
- Divide by zero: 37 / 0 -> quotient = 255, remainder = 0, div_by_zero = 1, out_valid one edge after accept.
- Backpressure: 100 / 9, with out_ready held low for 5 cycles after out_valid.
  - quotient = 11 and remainder = 1 stay stable.
  - in_ready stays 0.
  - A request driven meanwhile is not accepted.
  - Retire, then in_ready = 1 next cycle.
- Reset mid-operation: accept 150 / 4, assert reset on the 3rd BUSY cycle.
  - Next cycle: in_ready = 1, out_valid = 0, all result outputs 0.
  - A following 9 / 2 yields quotient = 4, remainder = 1.
- Exhaustive sweep: every lhs, rhs in 0..15 with rhs != 0, dividend = lhs*rhs -> quotient = lhs, remainder = 0.
